// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, per-mode schedule constants,
// the S-box table and the GF(2^8) xtime helper.
package aes_pkg;

   typedef enum logic [1:0] {
      KL_128  = 2'b00,
      KL_192  = 2'b01,
      KL_256  = 2'b10,
      KL_RSVD = 2'b11
   } key_len_e;

   localparam int NK_128 = 4;
   localparam int NK_192 = 6;
   localparam int NK_256 = 8;
   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;
   localparam int WORDS_128 = 4 * (NR_128 + 1);
   localparam int WORDS_192 = 4 * (NR_192 + 1);
   localparam int WORDS_256 = 4 * (NR_256 + 1);

   // Entry k lives at bits [2047-8k -: 8].
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic int nk_of(input key_len_e kl);
      case (kl)
         KL_128:  return NK_128;
         KL_192:  return NK_192;
         default: return NK_256;
      endcase
   endfunction

   function automatic logic [2:0] nk_m1_of(input key_len_e kl);
      case (kl)
         KL_128:  return 3'(NK_128 - 1);
         KL_192:  return 3'(NK_192 - 1);
         default: return 3'(NK_256 - 1);
      endcase
   endfunction

   function automatic logic [5:0] last_addr_of(input key_len_e kl);
      case (kl)
         KL_128:  return 6'(WORDS_128 - 1);
         KL_192:  return 6'(WORDS_192 - 1);
         default: return 6'(WORDS_256 - 1);
      endcase
   endfunction

endpackage

// File: rtl/aes_key_schedule_otf_if.sv
// Load/stream bundle between the cipher controller and the on-the-fly key schedule.
interface aes_key_schedule_otf_if;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key;
   logic         rk_valid;
   logic         rk_ready;
   logic [31:0]  rk_word;
   logic [5:0]   rk_addr;
   logic [3:0]   rk_round;
   logic         rk_last;
   logic         busy;
   logic         err;

   modport master (
      output start, key_len, key, rk_ready,
      input  rk_valid, rk_word, rk_addr, rk_round, rk_last, busy, err
   );

   modport slave (
      input  start, key_len, key, rk_ready,
      output rk_valid, rk_word, rk_addr, rk_round, rk_last, busy, err
   );
endinterface

// File: rtl/aes_key_schedule_otf_word_gen.sv
// Combinational next-word unit: w[j] = w[j-Nk] ^ f(w[j-1]).
module aes_key_schedule_otf_word_gen (
   input  logic [31:0] w_first,
   input  logic [31:0] w_last,
   input  logic        rot_sub,
   input  logic        sub_only,
   input  logic [7:0]  rcon,
   output logic [31:0] w_new
);
   logic [31:0] sub_in;
   logic [31:0] sub_out;
   logic [31:0] f_word;

   // RotWord is folded in front of the S-boxes so one set of four serves both cases.
   assign sub_in = rot_sub ? {w_last[23:0], w_last[31:24]} : w_last;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (sub_in[8*b +: 8]),
         .out_byte (sub_out[8*b +: 8])
      );
   end

   // NOTE: assign a default before any branch so no path leaves f_word unassigned (no latch).
   always_comb begin
      f_word = w_last;
      if (rot_sub)       f_word = sub_out ^ {rcon, 24'h0};
      else if (sub_only) f_word = sub_out;
   end

   assign w_new = w_first ^ f_word;
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box as a single combinational table lookup.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);
   logic [10:0] bit_idx;

   // Entry k sits at offset 8*(255-k); 255-k is just ~k for a byte.
   assign bit_idx  = {~in_byte, 3'b000};
   assign out_byte = SBOX_TABLE[bit_idx +: 8];
endmodule

// File: rtl/aes_key_schedule_otf.sv
// Word-serial AES-128/192/256 key schedule keeping only a sliding Nk-word window.
module aes_key_schedule_otf
   import aes_pkg::*;
#(
   parameter int MAX_NK = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   aes_key_schedule_otf_if.slave bus
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]  state;
   logic [31:0] win [MAX_NK];
   key_len_e    kl_q;
   logic [2:0]  nk_m1_q;
   logic [2:0]  phase_q;
   logic [5:0]  addr_q;
   logic [5:0]  last_addr_q;
   logic [7:0]  rcon_q;
   logic        last_q;
   logic        err_q;

   key_len_e    kl_in;
   logic        supported;
   logic        xfer;
   logic        rot_sub;
   logic        sub_only;
   logic [31:0] w_last;
   logic [31:0] w_new;

   assign kl_in     = key_len_e'(bus.key_len);
   assign supported = (kl_in != KL_RSVD) && (nk_of(kl_in) <= MAX_NK);
   assign xfer      = (state == ST_RUN) && bus.rk_ready;

   // phase_q tracks j mod Nk for the word about to be generated.
   assign rot_sub  = (phase_q == 3'd0);
   assign sub_only = (kl_q == KL_256) && (phase_q == 3'd4);

   always_comb begin
      w_last = win[0];
      for (int k = 0; k < MAX_NK; k++) begin
         if (int'(nk_m1_q) == k) w_last = win[k];
      end
   end

   aes_key_schedule_otf_word_gen u_word_gen (
      .w_first  (win[0]),
      .w_last   (w_last),
      .rot_sub  (rot_sub),
      .sub_only (sub_only),
      .rcon     (rcon_q),
      .w_new    (w_new)
   );

   // NOTE: the window is a handful of flops, not a RAM, so it is reset along with the control state.
   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         kl_q        <= KL_128;
         nk_m1_q     <= 3'(NK_128 - 1);
         phase_q     <= 3'd0;
         addr_q      <= 6'd0;
         last_addr_q <= 6'(WORDS_128 - 1);
         rcon_q      <= 8'h01;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
         for (int k = 0; k < MAX_NK; k++) win[k] <= 32'h0;
      end else begin
         err_q <= bus.start && !supported;
         if (bus.start) begin
            // A load pre-empts any same-cycle transfer.
            last_q <= 1'b0;
            if (supported) begin
               state       <= ST_RUN;
               kl_q        <= kl_in;
               nk_m1_q     <= nk_m1_of(kl_in);
               last_addr_q <= last_addr_of(kl_in);
               addr_q      <= 6'd0;
               phase_q     <= 3'd0;
               rcon_q      <= 8'h01;
               for (int k = 0; k < MAX_NK; k++) win[k] <= bus.key[255-32*k -: 32];
            end else begin
               state <= ST_IDLE;
            end
         end else if (xfer) begin
            for (int k = 0; k < MAX_NK - 1; k++) begin
               win[k] <= (int'(nk_m1_q) == k) ? w_new : win[k+1];
            end
            win[MAX_NK-1] <= (int'(nk_m1_q) == MAX_NK - 1) ? w_new : win[MAX_NK-1];
            phase_q <= (phase_q == nk_m1_q) ? 3'd0 : phase_q + 3'd1;
            if (rot_sub) rcon_q <= xtime(rcon_q);
            if (last_q) begin
               state  <= ST_IDLE;
               last_q <= 1'b0;
            end else begin
               addr_q <= addr_q + 6'd1;
               last_q <= (addr_q + 6'd1 == last_addr_q);
            end
         end
      end
   end

   assign bus.rk_valid = (state == ST_RUN);
   assign bus.busy     = (state == ST_RUN);
   assign bus.rk_word  = win[0];
   assign bus.rk_addr  = addr_q;
   assign bus.rk_round = addr_q[5:2];
   assign bus.rk_last  = last_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_aes_key_schedule_otf.sv
// Directed bench for the on-the-fly key schedule with an independent expansion model and scoreboard.
module tb_aes_key_schedule_otf;
   typedef struct {
      logic [5:0]  addr;
      logic [31:0] word;
      logic        last;
   } exp_t;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KB   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   aes_key_schedule_otf_if bus ();
   aes_key_schedule_otf_if bus6 ();

   aes_key_schedule_otf #(.MAX_NK(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   aes_key_schedule_otf #(.MAX_NK(6)) dut6 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus6)
   );

   int          errors = 0;
   int          checks = 0;
   exp_t        sb_q[$];
   logic [7:0]  sbox_m [256];
   logic [31:0] cap [64];
   int          last_seen;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // S-box derived from the field inverse and affine map, not copied from a table.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_w(input logic [31:0] x);
      return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
   endfunction

   task automatic push_schedule(input logic [1:0] kl, input logic [255:0] key);
      logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      logic [31:0] w [60];
      logic [31:0] t;
      int nk, total;
      exp_t e;
      nk    = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
      total = (kl == 2'b00) ? 44 : (kl == 2'b01) ? 52 : 60;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < total; i++) begin
         t = w[i-1];
         if (i % nk == 0) t = sub_w({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
         else if (nk == 8 && i % nk == 4) t = sub_w(t);
         w[i] = w[i-nk] ^ t;
      end
      sb_q.delete();
      for (int i = 0; i < total; i++) begin
         e.addr = 6'(i);
         e.word = w[i];
         e.last = (i == total - 1);
         sb_q.push_back(e);
      end
      for (int i = 0; i < 64; i++) cap[i] = 32'hx;
      last_seen = -1;
   endtask

   // Caller is at posedge+1; start is held for exactly one clock.
   task automatic load(input logic [1:0] kl, input logic [255:0] key);
      bus.start   = 1'b1;
      bus.key_len = kl;
      bus.key     = key;
      if (kl != 2'b11) push_schedule(kl, key);
      else sb_q.delete();
      @(posedge clk) #1;
      bus.start = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(posedge clk) #1;
         bus.rk_ready = 1'b1;
         n++;
      end
      check({tag, "_drained"}, 64'(sb_q.size()), 64'd0);
      check({tag, "_busy_low"}, {62'd0, bus.busy, bus.rk_valid}, 64'd0);
   endtask

   // Scoreboard monitor: samples on the falling edge, away from the active edge.
   initial begin
      exp_t e;
      logic        stall_prev = 1'b0;
      logic [31:0] s_word;
      logic [5:0]  s_addr;
      logic        s_last;
      forever begin
         @(negedge clk);
         if (rst_n && stall_prev && !bus.start) begin
            check("stall_hold", {25'd0, bus.rk_last, bus.rk_addr, bus.rk_word},
                  {25'd0, s_last, s_addr, s_word});
         end
         if (rst_n && bus.rk_valid && bus.rk_ready && !bus.start) begin
            if (sb_q.size() == 0) begin
               check("unexpected_word", {32'd0, bus.rk_word}, 64'hx);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("word[%0d]", e.addr), {26'd0, bus.rk_addr, bus.rk_word}, {26'd0, e.addr, e.word});
               check($sformatf("last/round[%0d]", e.addr), {59'd0, bus.rk_last, bus.rk_round},
                     {59'd0, e.last, e.addr[5:2]});
               cap[e.addr] = bus.rk_word;
               if (bus.rk_last) last_seen = int'(bus.rk_addr);
            end
         end
         stall_prev = rst_n && bus.rk_valid && !bus.rk_ready && !bus.start;
         s_word = bus.rk_word;
         s_addr = bus.rk_addr;
         s_last = bus.rk_last;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.key_len = 2'b00; bus.key = '0; bus.rk_ready = 1'b1;
      bus6.start = 1'b0; bus6.key_len = 2'b00; bus6.key = '0; bus6.rk_ready = 1'b1;
      build_sbox();
      #12;
      check("reset_outputs", {bus.rk_valid, bus.busy, bus.err, bus.rk_last, bus.rk_round, bus.rk_addr, bus.rk_word},
            64'd0);
      rst_n = 1'b1;

      // AES-128 free-running.
      @(posedge clk) #1;
      load(2'b00, K128);
      check("k128_first_valid", {31'd0, bus.rk_valid, bus.rk_word}, {31'd0, 1'b1, K128[255:224]});
      drain("k128", 100);
      check("k128_w4", {32'd0, cap[4]}, {32'd0, 32'ha0fafe17});
      check("k128_w43", {32'd0, cap[43]}, {32'd0, 32'hb6630ca6});
      check("k128_last_addr", 64'(last_seen), 64'd43);

      // AES-192 free-running.
      @(posedge clk) #1;
      load(2'b01, K192);
      drain("k192", 100);
      check("k192_w6", {32'd0, cap[6]}, {32'd0, 32'hfe0c91f7});
      check("k192_w51", {32'd0, cap[51]}, {32'd0, 32'h01002202});
      check("k192_last_addr", 64'(last_seen), 64'd51);

      // AES-192 with random backpressure.
      @(posedge clk) #1;
      load(2'b01, K192);
      n = 0;
      while (sb_q.size() != 0 && n < 600) begin
         bus.rk_ready = 1'($urandom_range(0, 1));
         @(posedge clk) #1;
         n++;
      end
      bus.rk_ready = 1'b1;
      drain("k192_bp", 10);
      check("k192_bp_w51", {32'd0, cap[51]}, {32'd0, 32'h01002202});

      // AES-256, including the SubWord-only step at w[12].
      @(posedge clk) #1;
      load(2'b10, K256);
      drain("k256", 100);
      check("k256_w8", {32'd0, cap[8]}, {32'd0, 32'h9ba35411});
      check("k256_w12", {32'd0, cap[12]}, {32'd0, 32'ha8b09c1a});
      check("k256_w59", {32'd0, cap[59]}, {32'd0, 32'h706c631e});

      // Restart mid-run at rk_addr 20 with a different AES-128 key.
      @(posedge clk) #1;
      load(2'b00, K128);
      n = 0;
      while (bus.rk_addr != 6'd20 && n < 60) begin
         @(posedge clk) #1;
         n++;
      end
      check("restart_reached_20", {58'd0, bus.rk_addr}, 64'd20);
      load(2'b00, KB);
      check("restart_first", {25'd0, bus.rk_valid, bus.rk_addr, bus.rk_word}, {25'd0, 1'b1, 6'd0, KB[255:224]});
      drain("restart", 100);

      // Reserved key_len from IDLE.
      @(posedge clk) #1;
      load(2'b11, K256);
      check("rsvd_err", {61'd0, bus.err, bus.rk_valid, bus.busy}, {61'd0, 3'b100});
      @(posedge clk) #1;
      check("rsvd_err_pulse", {61'd0, bus.err, bus.rk_valid, bus.busy}, 64'd0);

      // Reserved key_len while running aborts to IDLE.
      load(2'b10, K256);
      repeat (5) @(posedge clk);
      #1;
      load(2'b11, K128);
      check("rsvd_run_err", {61'd0, bus.err, bus.rk_valid, bus.busy}, {61'd0, 3'b100});

      // AES-256 on a MAX_NK=6 instance is rejected; AES-192 still loads.
      bus6.start = 1'b1; bus6.key_len = 2'b10; bus6.key = K256;
      @(posedge clk) #1;
      bus6.start = 1'b0;
      check("nk6_k256_err", {61'd0, bus6.err, bus6.rk_valid, bus6.busy}, {61'd0, 3'b100});
      bus6.start = 1'b1; bus6.key_len = 2'b01; bus6.key = K192;
      @(posedge clk) #1;
      bus6.start = 1'b0;
      check("nk6_k192_load", {30'd0, bus6.err, bus6.rk_valid, bus6.rk_word}, {30'd0, 2'b01, K192[255:224]});
      n = 0;
      while (bus6.rk_addr != 6'd6 && n < 20) begin
         @(posedge clk) #1;
         n++;
      end
      check("nk6_k192_w6", {26'd0, bus6.rk_addr, bus6.rk_word}, {26'd0, 6'd6, 32'hfe0c91f7});

      // Asynchronous reset in the middle of a run.
      load(2'b00, K128);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("async_reset", {bus.rk_valid, bus.busy, bus.err, bus.rk_last, bus.rk_round, bus.rk_addr, bus.rk_word},
            64'd0);
      @(negedge clk) #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("after_reset_idle", {62'd0, bus.rk_valid, bus.busy}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
